// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// The error-cause constants index the responder's cause vector.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_RANGE    = 1;
   localparam int ERR_CONFLICT = 2;
   localparam int ERR_W        = 3;

   function automatic int idx_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, asynchronous read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int IW    = idx_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [IW-1:0] widx_i,
   input  logic [31:0]   wdata_i,
   input  logic [IW-1:0] ridx_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   // NOTE: storage is deliberately not reset; contents must survive rst_i and a reset port would block RAM mapping.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder between EXMEM and MEMWB: one request at a time,
// fixed access latency, one-cycle ack/err pulse, stall to the hazard unit while busy.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 3,
   parameter int AW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          MemRead_i,
   input  logic          MemWrite_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   data_i,
   output logic [31:0]   data_o,
   output logic          ack_o,
   output logic          err_o,
   output logic          stall_o
);

   localparam int IW = idx_width(DEPTH);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [IW-1:0]   idx_q;
   logic [31:0]     wdata_q;
   logic            write_q;
   logic            err_q;

   logic            req;
   logic            accept;
   logic [ERR_W-1:0] cause;
   logic            we;
   logic [31:0]     rdata;

   assign req    = MemRead_i | MemWrite_i;
   assign accept = (state_q == IDLE) && req;

   // Errors are resolved at accept time so no later input change can affect them.
   always_comb begin
      cause               = '0;
      cause[ERR_MISALIGN] = |addr_i[1:0];
      cause[ERR_RANGE]    = |addr_i[AW-1:IW+2];
      cause[ERR_CONFLICT] = MemRead_i & MemWrite_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            idx_q   <= addr_i[IW+1:2];
            wdata_q <= data_i;
            write_q <= MemWrite_i;
            err_q   <= |cause;
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               cnt_d   = 4'(LATENCY - 1);
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // stall is gated by rst_i so a held request cannot raise it during reset.
   always_comb begin
      ack_o   = (state_q == RESP);
      err_o   = ack_o & err_q;
      data_o  = (ack_o && !write_q && !err_q) ? rdata : 32'h0;
      stall_o = (state_q == BUSY) || (accept && rst_i);
      we      = ack_o && write_q && !err_q;
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (we),
      .widx_i  (idx_q),
      .wdata_i (wdata_q),
      .ridx_i  (idx_q),
      .rdata_o (rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 3, 1, 4) checked every cycle
// against a transaction-level model, plus directed literal expectations.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rd    [3];
   logic        wr    [3];
   logic [31:0] addr  [3];
   logic [31:0] wd    [3];
   logic [31:0] dout  [3];
   logic        ack   [3];
   logic        err   [3];
   logic        stall [3];

   int checks   = 0;
   int failures = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
         .DEPTH   (256),
         .LATENCY ((g == 0) ? 3 : ((g == 1) ? 1 : 4)),
         .AW      (32)
      ) u_dut (
         .clk_i      (clk),
         .rst_i      (rst_n),
         .MemRead_i  (rd[g]),
         .MemWrite_i (wr[g]),
         .addr_i     (addr[g]),
         .data_i     (wd[g]),
         .data_o     (dout[g]),
         .ack_o      (ack[g]),
         .err_o      (err[g]),
         .stall_o    (stall[g])
      );
   end

   function automatic int lat_of(input int k);
      case (k)
         0:       return 3;
         1:       return 1;
         default: return 4;
      endcase
   endfunction

   function automatic bit bad_req(input logic r, input logic w, input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= 32'h400) || (r && w);
   endfunction

   // Transaction model: a pending request is answered at cycle accept+LATENCY.
   int          cyc = 0;
   bit          pend  [3];
   int          due   [3];
   bit          m_wr  [3];
   bit          m_err [3];
   logic [7:0]  m_idx [3];
   logic [31:0] m_d   [3];
   logic [31:0] mm    [3][256];
   bit          known [3][256];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (!rst_n) begin
            pend[k] <= 1'b0;
         end else if (!pend[k]) begin
            if (rd[k] || wr[k]) begin
               pend[k]  <= 1'b1;
               due[k]   <= cyc + lat_of(k);
               m_wr[k]  <= wr[k];
               m_err[k] <= bad_req(rd[k], wr[k], addr[k]);
               m_idx[k] <= addr[k][9:2];
               m_d[k]   <= wd[k];
            end
         end else if (cyc == due[k]) begin
            if (m_wr[k] && !m_err[k]) begin
               mm[k][m_idx[k]]    <= m_d[k];
               known[k][m_idx[k]] <= 1'b1;
            end
            pend[k] <= 1'b0;
         end
      end
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      logic        e_ack, e_err, e_stall;
      logic [31:0] e_d;
      bit          dk;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               e_ack = 1'b0; e_err = 1'b0; e_stall = 1'b0; e_d = 32'h0; dk = 1'b1;
            end else begin
               e_ack   = pend[k] && (cyc == due[k]);
               e_stall = pend[k] ? !e_ack : (rd[k] || wr[k]);
               e_err   = e_ack && m_err[k];
               e_d     = 32'h0;
               dk      = 1'b1;
               if (e_ack && !m_wr[k] && !m_err[k]) begin
                  e_d = mm[k][m_idx[k]];
                  dk  = known[k][m_idx[k]];
               end
            end
            check($sformatf("ack[%0d]", k),   32'(ack[k]),   32'(e_ack));
            check($sformatf("err[%0d]", k),   32'(err[k]),   32'(e_err));
            check($sformatf("stall[%0d]", k), 32'(stall[k]), 32'(e_stall));
            if (dk) check($sformatf("data[%0d]", k), dout[k], e_d);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Presents a request and holds it until ack; lat counts cycles from accept to ack.
   task automatic txn(input int k, input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit scramble,
                      output logic [31:0] dat, output logic e, output int lat, output int stalls);
      bit found;
      found  = 1'b0;
      dat    = 32'h0;
      e      = 1'b0;
      lat    = -1;
      stalls = 0;
      rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (ack[k]) begin
            found = 1'b1;
            dat   = dout[k];
            e     = err[k];
            lat   = i;
         end else if (stall[k]) begin
            stalls++;
         end
         step();
         if (scramble && !found) begin
            addr[k] = addr[k] ^ 32'h4;
            wd[k]   = ~wd[k];
         end
      end
      rd[k] = 1'b0; wr[k] = 1'b0;
      check($sformatf("txn_done[%0d]", k), 32'(found), 32'd1);
   endtask

   logic [31:0] dat;
   logic        e;
   int          lat, stalls, acks, consec;
   logic        prev;

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'h0; wd[k] = 32'h0;
      end
      fork
         compare_loop();
      join_none
      repeat (3) @(posedge clk);
      #2;
      check("reset_ack",   32'(ack[0]),   32'd0);
      check("reset_stall", 32'(stall[0]), 32'd0);
      check("reset_data",  dout[0],       32'h0);
      rst_n = 1'b1;
      step();

      // LATENCY=3 instance
      txn(0, 1'b0, 1'b1, 32'h0,  32'hCAFEF00D, 1'b0, dat, e, lat, stalls);
      txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, dat, e, lat, stalls);
      check("st10_lat",    32'(lat),    32'd3);
      check("st10_stalls", 32'(stalls), 32'd3);
      check("st10_err",    32'(e),      32'd0);
      check("st10_data",   dat,         32'h0);
      txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, dat, e, lat, stalls);
      check("ld10_data", dat, 32'hDEADBEEF);
      check("ld10_err",  32'(e), 32'd0);
      txn(0, 1'b1, 1'b0, 32'h12, 32'h0, 1'b0, dat, e, lat, stalls);
      check("misalign_err",  32'(e), 32'd1);
      check("misalign_data", dat,    32'h0);
      txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, dat, e, lat, stalls);
      check("ld10_again", dat, 32'hDEADBEEF);
      txn(0, 1'b0, 1'b1, 32'h400, 32'h1, 1'b0, dat, e, lat, stalls);
      check("range_err", 32'(e), 32'd1);
      txn(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, dat, e, lat, stalls);
      check("no_alias", dat, 32'hCAFEF00D);
      txn(0, 1'b0, 1'b1, 32'h20, 32'h5555AAAA, 1'b0, dat, e, lat, stalls);
      txn(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b0, dat, e, lat, stalls);
      check("conflict_err",  32'(e), 32'd1);
      check("conflict_data", dat,    32'h0);
      txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, dat, e, lat, stalls);
      check("conflict_nowrite", dat, 32'h5555AAAA);

      // Reset while a store is in BUSY
      txn(0, 1'b0, 1'b1, 32'h30, 32'h12345678, 1'b0, dat, e, lat, stalls);
      wr[0] = 1'b1; addr[0] = 32'h30; wd[0] = 32'hA5A5A5A5;
      step();
      check("busy_stall", 32'(stall[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_stall", 32'(stall[0]), 32'd0);
      check("rst_mid_ack",   32'(ack[0]),   32'd0);
      check("rst_mid_data",  dout[0],       32'h0);
      step();
      step();
      wr[0] = 1'b0;
      rst_n = 1'b1;
      step();
      txn(0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, dat, e, lat, stalls);
      check("rst_no_write", dat, 32'h12345678);

      // LATENCY=1 instance: back-to-back loads
      txn(1, 1'b0, 1'b1, 32'h8, 32'h0BADC0DE, 1'b0, dat, e, lat, stalls);
      check("l1_lat", 32'(lat), 32'd1);
      rd[1] = 1'b1; addr[1] = 32'h8;
      acks = 0; consec = 0; prev = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ack[1]) acks++;
         if (ack[1] && prev) consec++;
         prev = ack[1];
         step();
      end
      rd[1] = 1'b0;
      check("l1_acks",  32'(acks),   32'd5);
      check("l1_consec", 32'(consec), 32'd0);

      // LATENCY=4 instance: inputs wander during BUSY
      txn(2, 1'b0, 1'b1, 32'h44, 32'h11111111, 1'b0, dat, e, lat, stalls);
      txn(2, 1'b0, 1'b1, 32'h40, 32'h22222222, 1'b1, dat, e, lat, stalls);
      check("l4_lat", 32'(lat), 32'd4);
      txn(2, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, dat, e, lat, stalls);
      check("l4_ld40", dat, 32'h22222222);
      txn(2, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1, dat, e, lat, stalls);
      check("l4_ld44", dat, 32'h11111111);

      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
